// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end for the vending FSM. Synchronises and debounces the raw quarter
//   and dollar sensor lines, turns each debounced rising edge into one coin
//   event, queues accepted coins and replays them as spaced, mutually
//   exclusive single-cycle pulses. Coins that cannot be taken are returned
//   through a one-cycle Reject pulse.
//
// Ports
//   Clock          rising-edge system clock
//   Reset          asynchronous, active-low reset
//   Quarter_Sense  raw quarter sensor (asynchronous, bouncy)
//   Dollar_Sense   raw dollar sensor (asynchronous, bouncy)
//   Enable         1 = accept coins, 0 = reject every new coin
//   Quarter_In     one-cycle pulse per accepted quarter
//   Dollar_In      one-cycle pulse per accepted dollar
//   Reject         one-cycle pulse opening the coin return gate
//   Pending        number of coins waiting in the queue
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2,
  parameter int unsigned QUEUE_DEPTH     = 2
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               Quarter_Sense,
  input  logic                               Dollar_Sense,
  input  logic                               Enable,
  output logic                               Quarter_In,
  output logic                               Dollar_In,
  output logic                               Reject,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   Pending
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PW:0]   DEPTH_W  = (PW + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  // Line index 0 = quarter, 1 = dollar.
  logic [1:0]    sense;
  logic [1:0]    sync1, sync2, filt, filt_d, rise;
  logic [DW-1:0] deb_cnt [2];

  logic                   q_ev, d_ev, q_acc, d_acc, pop, reject_n;
  logic [PW:0]            free;
  logic [QUEUE_DEPTH-1:0] fifo, fifo_n;   // bit 0 is the head; 1 = dollar
  logic [PW-1:0]          count, count_n;
  state_t                 state, state_n;
  logic [GW-1:0]          gap_cnt, gap_cnt_n;

  assign sense = {Dollar_Sense, Quarter_Sense};

  // Synchroniser and debounce filter for both lines.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1  <= sense;
      sync2  <= sync1;
      filt_d <= filt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          filt[i]    <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // filt_d resets to 0, so a line already high at reset release still
  // produces one event once its filtered level rises.
  assign rise = filt & ~filt_d;
  assign q_ev = rise[0];
  assign d_ev = rise[1];

  // Output sequencer: next state and pop decision.
  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        gap_cnt_n = '0;
        state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        // The IDLE check is folded into the last gap cycle so the idle time
        // between two pulses is exactly GAP_CYCLES.
        if (gap_cnt == GAP_LAST) begin
          if (count != '0) begin
            pop     = 1'b1;
            state_n = EMIT;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Acceptance and queue update. A pop on the same edge frees a slot;
  // the dollar claims the first free slot, the quarter the next.
  always_comb begin
    free     = DEPTH_W - {1'b0, count} + {{PW{1'b0}}, pop};
    d_acc    = Enable && d_ev && (free != '0);
    q_acc    = Enable && q_ev && (free > {{PW{1'b0}}, d_acc});
    reject_n = (d_ev && !d_acc) || (q_ev && !q_acc);

    fifo_n  = fifo;
    count_n = count;
    if (pop) begin
      fifo_n  = fifo >> 1;
      count_n = count - 1'b1;
    end
    if (d_acc) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++)
        if (PW'(i) == count_n) fifo_n[i] = 1'b1;
      count_n = count_n + 1'b1;
    end
    if (q_acc) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++)
        if (PW'(i) == count_n) fifo_n[i] = 1'b0;
      count_n = count_n + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      fifo       <= '0;
      count      <= '0;
      Quarter_In <= 1'b0;
      Dollar_In  <= 1'b0;
      Reject     <= 1'b0;
    end else begin
      state      <= state_n;
      gap_cnt    <= gap_cnt_n;
      fifo       <= fifo_n;
      count      <= count_n;
      Quarter_In <= pop & ~fifo[0];
      Dollar_In  <= pop & fifo[0];
      Reject     <= reject_n;
    end
  end

  assign Pending = count;

endmodule
